// File: rtl/axi4_slave_mem_if.sv
// axi4_slave_mem_if
// AXI4-Full bus bundle for axi4_slave_mem. The burst-only subset is carried:
// there are no SIZE/LOCK/CACHE/PROT/QOS/USER signals.
//   AW: awid, awaddr, awlen, awburst, awvalid, awready
//   W : wdata, wstrb, wlast, wvalid, wready
//   B : bid, bresp, bvalid, bready
//   AR: arid, araddr, arlen, arburst, arvalid, arready
//   R : rid, rdata, rresp, rlast, rvalid, rready
// Modports: master (drives requests) and slave (drives ready/responses).
//
// Handshake rule, on every channel: a transfer happens on a rising clock edge
// where valid && ready are both high. Once valid is raised, the source holds
// it and every payload signal stable until that transfer happens.
interface axi4_slave_mem_if #(
   parameter int ID_WIDTH   = 1,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ID_WIDTH-1:0]     awid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;

   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;

   logic [ID_WIDTH-1:0]     bid;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   logic [ID_WIDTH-1:0]     arid;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic [1:0]              arburst;
   logic                    arvalid;
   logic                    arready;

   logic [ID_WIDTH-1:0]     rid;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awid, awaddr, awlen, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

   modport master (
      output awid, awaddr, awlen, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );
endinterface

// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem
// AXI4-Full slave backed by a word-addressed RAM with byte strobes. One write
// burst and one read burst may be in flight at a time, on independent FSMs.
// FIXED and INCR bursts are served; INCR wraps at the top of memory. Burst
// types 10/11 answer SLVERR (writes dropped, reads return zeros).
// Ports:
//   S_AXI_ACLK    : clock, rising edge
//   S_AXI_ARESETN : asynchronous active-low reset (RAM contents are kept)
//   s_axi         : axi4_slave_mem_if.slave bus
//   w_state_dbg   : current write FSM state (W_IDLE=0, W_DATA=1, W_RESP=2)
//   r_state_dbg   : current read FSM state (R_IDLE=0, R_DATA=1)
// Optional feature: define AXI_SLV_BACKPRESSURE_EN to insert a one-cycle
// WREADY/RVALID bubble after every accepted data beat.
module axi4_slave_mem #(
   parameter int C_S_AXI_ID_WIDTH      = 1,
   parameter int C_S_AXI_ADDR_WIDTH    = 32,
   parameter int C_S_AXI_DATA_WIDTH    = 32,
   parameter int C_S_AXI_MEM_ADDR_BITS = 10
) (
   input  logic                 S_AXI_ACLK,
   input  logic                 S_AXI_ARESETN,
   axi4_slave_mem_if.slave      s_axi,
   output logic [1:0]           w_state_dbg,
   output logic                 r_state_dbg
);
   localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
   localparam int OFF    = $clog2(STRB_W);
   localparam int IDX_HI = C_S_AXI_MEM_ADDR_BITS + OFF - 1;
   localparam int DEPTH  = 1 << C_S_AXI_MEM_ADDR_BITS;
   localparam logic [C_S_AXI_MEM_ADDR_BITS-1:0] IDX_ONE = 1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic w_keep;

   // Write burst context
   logic [C_S_AXI_ID_WIDTH-1:0]      w_id;
   logic [C_S_AXI_MEM_ADDR_BITS-1:0] w_idx;
   logic [7:0]                       w_len;
   logic [8:0]                       w_cnt;   // beats accepted so far, saturating
   logic                             w_ok;
   logic                             w_fixed;

   // Read burst context
   logic [C_S_AXI_MEM_ADDR_BITS-1:0] ar_idx;
   logic [C_S_AXI_MEM_ADDR_BITS-1:0] r_idx;   // index of the NEXT beat to fetch
   logic [7:0]                       r_len;
   logic [7:0]                       r_cnt;   // index of the beat on the bus
   logic                             r_ok;
   logic                             r_fixed;

   // Address bits above the memory and below the word offset are ignored.
   logic unused_addr;
   assign unused_addr = ^{s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:IDX_HI+1], s_axi.awaddr[OFF-1:0],
                          s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:IDX_HI+1], s_axi.araddr[OFF-1:0]};

   assign aw_hs  = s_axi.awvalid && s_axi.awready;
   assign w_hs   = s_axi.wvalid  && s_axi.wready;
   assign b_hs   = s_axi.bvalid  && s_axi.bready;
   assign ar_hs  = s_axi.arvalid && s_axi.arready;
   assign r_hs   = s_axi.rvalid  && s_axi.rready;
   assign ar_idx = s_axi.araddr[IDX_HI:OFF];

   assign w_state_dbg = w_state;
   assign r_state_dbg = r_state;

   // ---------------- write FSM ----------------
   always_comb begin
      w_next = w_state;
      w_keep = 1'b0;
      case (w_state)
         W_IDLE: if (aw_hs) w_next = W_DATA;
         W_DATA: begin
            // Beats past AWLEN+1 are accepted but not stored.
            w_keep = w_hs && w_ok && (w_cnt <= {1'b0, w_len});
            if (w_hs && s_axi.wlast) w_next = W_RESP;
         end
         W_RESP: if (b_hs) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // Ready/valid are registered from the next state so they are 0 in reset
   // and rise on the first edge after release.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         w_state       <= W_IDLE;
         s_axi.awready <= 1'b0;
         s_axi.wready  <= 1'b0;
         s_axi.bvalid  <= 1'b0;
      end else begin
         w_state       <= w_next;
         s_axi.awready <= (w_next == W_IDLE);
`ifdef AXI_SLV_BACKPRESSURE_EN
         s_axi.wready  <= (w_next == W_DATA) && !w_hs;
`else
         s_axi.wready  <= (w_next == W_DATA);
`endif
         s_axi.bvalid  <= (w_next == W_RESP);
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         w_id        <= '0;
         w_idx       <= '0;
         w_len       <= '0;
         w_cnt       <= '0;
         w_ok        <= 1'b0;
         w_fixed     <= 1'b0;
         s_axi.bid   <= '0;
         s_axi.bresp <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            w_id    <= s_axi.awid;
            w_idx   <= s_axi.awaddr[IDX_HI:OFF];
            w_len   <= s_axi.awlen;
            w_cnt   <= '0;
            w_ok    <= !s_axi.awburst[1];
            w_fixed <= (s_axi.awburst == 2'b00);
         end
         if (w_hs) begin
            if (!w_fixed) w_idx <= w_idx + IDX_ONE;
            if (w_cnt != 9'h1FF) w_cnt <= w_cnt + 9'd1;
            if (s_axi.wlast) begin
               s_axi.bid <= w_id;
               // w_cnt excludes the WLAST beat itself, so a correct burst has w_cnt == AWLEN.
               s_axi.bresp <= (!w_ok || (w_cnt != {1'b0, w_len})) ? RESP_SLVERR : RESP_OKAY;
            end
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (w_keep) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (s_axi.wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
         end
      end
   end

   // ---------------- read FSM ----------------
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE: if (ar_hs) r_next = R_DATA;
         R_DATA: if (r_hs && s_axi.rlast) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state       <= R_IDLE;
         s_axi.arready <= 1'b0;
         s_axi.rvalid  <= 1'b0;
      end else begin
         r_state       <= r_next;
         s_axi.arready <= (r_next == R_IDLE);
`ifdef AXI_SLV_BACKPRESSURE_EN
         s_axi.rvalid  <= (r_next == R_DATA) && !r_hs;
`else
         s_axi.rvalid  <= (r_next == R_DATA);
`endif
      end
   end

   // RDATA is fetched one beat ahead: beat 0 on the AR handshake, each later
   // beat on the handshake of the previous one, so it only changes on a
   // transfer and a same-edge write to that word is not yet visible.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_idx       <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_ok        <= 1'b0;
         r_fixed     <= 1'b0;
         s_axi.rid   <= '0;
         s_axi.rdata <= '0;
         s_axi.rresp <= RESP_OKAY;
         s_axi.rlast <= 1'b0;
      end else if (ar_hs) begin
         r_len       <= s_axi.arlen;
         r_cnt       <= '0;
         r_ok        <= !s_axi.arburst[1];
         r_fixed     <= (s_axi.arburst == 2'b00);
         r_idx       <= (s_axi.arburst == 2'b00) ? ar_idx : ar_idx + IDX_ONE;
         s_axi.rid   <= s_axi.arid;
         s_axi.rdata <= s_axi.arburst[1] ? '0 : mem[ar_idx];
         s_axi.rresp <= s_axi.arburst[1] ? RESP_SLVERR : RESP_OKAY;
         s_axi.rlast <= (s_axi.arlen == 8'd0);
      end else if (r_hs && !s_axi.rlast) begin
         r_cnt       <= r_cnt + 8'd1;
         if (!r_fixed) r_idx <= r_idx + IDX_ONE;
         s_axi.rdata <= r_ok ? mem[r_idx] : '0;
         s_axi.rlast <= ((r_cnt + 8'd1) == r_len);
      end
   end
endmodule
